pool_window_gen: RTL

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_window_gen_if.sv | 40 ++++
 rtl/pool_window_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pool_window_gen_if.sv
// rtl/pool_window_gen_if.sv - pixel stream in / 2x2 window out bundle for pool_window_gen
//
// Signals (master = pixel producer / window consumer, slave = pool_window_gen):
//   clear      producer -> gen  synchronous frame restart
//   in_valid   producer -> gen  in_data carries a pixel this cycle
//   in_data    producer -> gen  unsigned pixel, raster order
//   win_valid  gen -> consumer  win_data holds a complete 2x2 window
//   win_data   gen -> consumer  [0]=top-left [1]=top-right [2]=bottom-left [3]=bottom-right
//   frame_done gen -> consumer  pulse alongside the last window of a frame

interface pool_window_gen_if #(
  parameter int BITWIDTH = 8
) ();

  logic                clear;
  logic                in_valid;
  logic [BITWIDTH-1:0] in_data;
  logic                win_valid;
  logic [BITWIDTH-1:0] win_data [3:0];
  logic                frame_done;

  modport master (
    output clear,
    output in_valid,
    output in_data,
    input  win_valid,
    input  win_data,
    input  frame_done
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    output win_valid,
    output win_data,
    output frame_done
  );

endinterface

// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - stride-2 non-overlapping 2x2 window generator for a raster pixel stream
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pool_window_gen_if.slave: clear/in_valid/in_data in,
//        win_valid/win_data/frame_done out (all outputs registered)
//
// Even rows are stored in a one-row line buffer. On odd rows the even-column
// pixel is parked in a left register; the odd-column pixel then completes the
// window {lb[c-1], lb[c], left, pixel}, which is registered and presented the
// following cycle.

module pool_window_gen #(
  parameter int BITWIDTH   = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  pool_window_gen_if.slave   bus
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  // Position of the next pixel to be accepted.
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;

  // Even-column pixel of the current odd row.
  logic [BITWIDTH-1:0] left_q, left_d;

  // Registered outputs.
  logic                win_valid_q, win_valid_d;
  logic                frame_done_q, frame_done_d;
  logic [BITWIDTH-1:0] win_data_q [3:0];
  logic [BITWIDTH-1:0] win_data_d [3:0];

  // Top row of the current band of windows; never reset, every entry is
  // rewritten on an even row before any odd row reads it.
  logic [BITWIDTH-1:0] lb_q [IMG_WIDTH];

  logic                accept;
  logic [COL_W-1:0]    col_pair;

  // clear has priority over a coincident pixel, which is dropped.
  assign accept   = bus.in_valid && !bus.clear;
  // Even column of the pair the current odd column belongs to.
  assign col_pair = col_q & ~COL_ONE;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    left_d       = left_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_data_d   = win_data_q;

    if (bus.clear) begin
      col_d = '0;
      row_d = '0;
    end else if (bus.in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end

      if (row_q[0]) begin
        if (!col_q[0]) begin
          left_d = bus.in_data;
        end else begin
          win_data_d[0] = lb_q[col_pair];
          win_data_d[1] = lb_q[col_q];
          win_data_d[2] = left_q;
          win_data_d[3] = bus.in_data;
          win_valid_d   = 1'b1;
          frame_done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        win_data_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_data_q   <= win_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !row_q[0]) begin
      lb_q[col_q] <= bus.in_data;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_data   = win_data_q;

endmodule
